// File: rtl/npc_pkg.sv
// Shared encodings for the next-PC generator: npc_op codes, FSM states, widths.
package npc_pkg;

  localparam int unsigned NPC_OP_W = 2;

  typedef enum logic [NPC_OP_W-1:0] {
    OP_ORDER  = 2'd0,
    OP_BRANCH = 2'd1,
    OP_JIMM   = 2'd2,
    OP_JREG   = 2'd3
  } npc_op_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } npc_state_e;

endpackage

// File: rtl/npc_target.sv
// Combinational redirect target and link address for the instruction in ID.
// ORDER selects the sequential slot address; the top only uses the target on a redirect.
module npc_target import npc_pkg::*; #(
  parameter int unsigned PC_W = 32
) (
  input  logic [NPC_OP_W-1:0] npc_op_i,
  input  logic [PC_W-1:0]     id_pc_i,
  input  logic [15:0]         imm16_i,
  input  logic [25:0]         jmp_addr_i,
  input  logic [31:0]         jmp_reg_i,
  output logic [PC_W-1:0]     target_o,
  output logic [PC_W-1:0]     pc_link_o
);

  logic [PC_W-1:0] slot;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] jimm_tgt;
  logic [PC_W-1:0] jreg_tgt;
  logic [31:0]     br_off;

  assign slot     = id_pc_i + PC_W'(4);
  assign br_off   = {{14{imm16_i[15]}}, imm16_i, 2'b00};
  assign br_tgt   = slot + br_off[PC_W-1:0];
  assign jreg_tgt = jmp_reg_i[PC_W-1:0];
  assign pc_link_o = id_pc_i + PC_W'(8);

  // With a 28-bit PC the 26-bit index plus byte offset fills the whole PC.
  generate
    if (PC_W > 28) begin : g_jimm_hi
      assign jimm_tgt = {slot[PC_W-1:28], jmp_addr_i, 2'b00};
    end else begin : g_jimm_lo
      assign jimm_tgt = {jmp_addr_i, 2'b00};
    end
  endgenerate

  // Select the target for the decoded control-flow kind.
  always_comb begin
    target_o = slot;
    case (npc_op_e'(npc_op_i))
      OP_BRANCH: target_o = br_tgt;
      OP_JIMM:   target_o = jimm_tgt;
      OP_JREG:   target_o = jreg_tgt;
      default:   target_o = slot;
    endcase
  end

endmodule

// File: rtl/npc_pcgen.sv
// IF-stage next-PC generator: owns the fetch PC, resolves ID redirects,
// parks a redirect as pending while imem is not ready, and handles
// exception entry / ERET. Optional perf counters under NPC_PERF_EN.
// Exception entry and ERET raise if_flush in both delay-slot modes, since
// the instruction behind a trap is never architecturally executed.
module npc_pcgen import npc_pkg::*; #(
  parameter int unsigned PC_W       = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_PC     = 32'h0000_4180,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                imem_ready,
  input  logic                id_valid,
  input  logic [NPC_OP_W-1:0] npc_op,
  input  logic                cmp,
  input  logic [PC_W-1:0]     id_pc,
  input  logic [15:0]         imm16,
  input  logic [25:0]         jmp_addr,
  input  logic [31:0]         jmp_reg,
  input  logic                exc_req,
  input  logic                eret_req,
  input  logic [PC_W-1:0]     epc,
  output logic [PC_W-1:0]     pc,
  output logic                pc_valid,
  output logic                if_flush,
  output logic                pc_misaligned,
  output logic [PC_W-1:0]     pc_link
`ifdef NPC_PERF_EN
  ,
  output logic [31:0]         redirect_cnt,
  output logic [31:0]         stall_cnt
`endif
);

  npc_state_e      state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pend_pc_q;
  logic            pc_valid_q;
  logic [PC_W-1:0] target;
  logic            fire;
  logic            redirect;
  logic            trap;

  npc_target #(.PC_W(PC_W)) u_target (
    .npc_op_i   (npc_op),
    .id_pc_i    (id_pc),
    .imm16_i    (imm16),
    .jmp_addr_i (jmp_addr),
    .jmp_reg_i  (jmp_reg),
    .target_o   (target),
    .pc_link_o  (pc_link)
  );

  assign fire     = pc_valid_q & imem_ready & ~stall;
  assign redirect = id_valid & ~stall &
                    ((npc_op == OP_JIMM) | (npc_op == OP_JREG) | ((npc_op == OP_BRANCH) & cmp));
  assign trap     = exc_req | eret_req;

  assign pc            = pc_q;
  assign pc_valid      = pc_valid_q;
  assign pc_misaligned = pc_valid_q & (pc_q[1:0] != 2'b00);
  // Gated by reset so the output is quiet while the block is held in reset.
  assign if_flush      = reset & (trap | (!DELAY_SLOT && redirect));

  // Fetch FSM: trap entry overrides everything, else BOOT->RUN<->PEND.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC[PC_W-1:0];
      pend_pc_q  <= '0;
      pc_valid_q <= 1'b0;
    end else if (trap) begin
      state_q    <= ST_RUN;
      pc_q       <= exc_req ? EXC_PC[PC_W-1:0] : epc;
      pend_pc_q  <= '0;
      pc_valid_q <= 1'b1;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q    <= ST_RUN;
          pc_valid_q <= 1'b1;
        end
        ST_RUN: begin
          if (fire) begin
            pc_q <= redirect ? target : pc_q + PC_W'(4);
          end else if (redirect) begin
            pend_pc_q <= target;
            state_q   <= ST_PEND;
          end
        end
        // A second redirect while one is pending is ignored.
        ST_PEND: begin
          if (fire) begin
            pc_q    <= pend_pc_q;
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q    <= ST_BOOT;
          pc_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef NPC_PERF_EN
  logic [31:0] redirect_cnt_q;
  logic [31:0] stall_cnt_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      if (redirect | trap)  redirect_cnt_q <= redirect_cnt_q + 32'd1;
      if (pc_valid_q & ~fire) stall_cnt_q  <= stall_cnt_q + 32'd1;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_npc_pcgen.sv
// Bench for npc_pcgen: directed steps from the test plan followed by random
// traffic, all checked against a behavioural model of the fetch PC.
// Two instances share the inputs: ds0 (DELAY_SLOT=0) and ds1 (default).
module tb_npc_pcgen;
  import npc_pkg::*;

  logic        clk = 1'b0;
  logic        reset, stall, imem_ready, id_valid, cmp, exc_req, eret_req;
  logic [1:0]  npc_op;
  logic [31:0] id_pc, jmp_reg, epc;
  logic [15:0] imm16;
  logic [25:0] jmp_addr;

  logic [31:0] pc0, pc1, link0, link1;
  logic        vld0, vld1, fl0, fl1, mis0, mis1;
`ifdef NPC_PERF_EN
  logic [31:0] rc0, sc0, rc1, sc1;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [31:0] m_pc, m_pend_pc;
  bit          m_valid, m_pend;
  logic [31:0] m_rcnt, m_scnt;

  always #5 clk = ~clk;

  npc_pcgen #(.DELAY_SLOT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
    .id_valid(id_valid), .npc_op(npc_op), .cmp(cmp), .id_pc(id_pc),
    .imm16(imm16), .jmp_addr(jmp_addr), .jmp_reg(jmp_reg),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .pc(pc0), .pc_valid(vld0), .if_flush(fl0), .pc_misaligned(mis0),
    .pc_link(link0)
`ifdef NPC_PERF_EN
    , .redirect_cnt(rc0), .stall_cnt(sc0)
`endif
  );

  npc_pcgen dut1 (
    .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
    .id_valid(id_valid), .npc_op(npc_op), .cmp(cmp), .id_pc(id_pc),
    .imm16(imm16), .jmp_addr(jmp_addr), .jmp_reg(jmp_reg),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .pc(pc1), .pc_valid(vld1), .if_flush(fl1), .pc_misaligned(mis1),
    .pc_link(link1)
`ifdef NPC_PERF_EN
    , .redirect_cnt(rc1), .stall_cnt(sc1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit is_redirect();
    if (!id_valid || stall) return 1'b0;
    return (npc_op == 2'd2) || (npc_op == 2'd3) || (npc_op == 2'd1 && cmp);
  endfunction

  // Target straight from the ISA rules, using plain 32-bit arithmetic.
  function automatic logic [31:0] model_target();
    logic [31:0] slot;
    int          off;
    slot = id_pc + 32'd4;
    off  = $signed(imm16) * 4;
    case (npc_op)
      2'd1:    return slot + 32'(off);
      2'd2:    return (slot & 32'hF000_0000) | (32'(jmp_addr) << 2);
      2'd3:    return jmp_reg;
      default: return slot;
    endcase
  endfunction

  // One clock: check outputs against the model, then advance the model.
  task automatic cyc();
    bit          fire, redir, trap;
    logic [31:0] tgt;
    #1;
    fire  = m_valid && imem_ready && !stall;
    redir = is_redirect();
    trap  = exc_req || eret_req;
    tgt   = model_target();
    chk("pc0", pc0, m_pc);
    chk("pc1", pc1, m_pc);
    chk("valid0", 32'(vld0), 32'(m_valid));
    chk("valid1", 32'(vld1), 32'(m_valid));
    chk("mis0", 32'(mis0), 32'(m_valid && (m_pc % 4 != 0)));
    chk("link0", link0, id_pc + 32'd8);
    chk("flush_ds0", 32'(fl0), 32'(trap || redir));
    chk("flush_ds1", 32'(fl1), 32'(trap));
`ifdef NPC_PERF_EN
    chk("rcnt", rc0, m_rcnt);
    chk("scnt", sc1, m_scnt);
`endif
    if (redir || trap) m_rcnt = m_rcnt + 1;
    if (m_valid && !fire) m_scnt = m_scnt + 1;
    if (exc_req) begin
      m_pc = 32'h0000_4180; m_pend = 0; m_valid = 1;
    end else if (eret_req) begin
      m_pc = epc; m_pend = 0; m_valid = 1;
    end else if (!m_valid) begin
      m_valid = 1;
    end else if (m_pend) begin
      if (fire) begin m_pc = m_pend_pc; m_pend = 0; end
    end else if (fire) begin
      m_pc = redir ? tgt : m_pc + 32'd4;
    end else if (redir) begin
      m_pend = 1; m_pend_pc = tgt;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 0; npc_op = 2'd0; cmp = 0; exc_req = 0; eret_req = 0;
    stall = 0; imem_ready = 1;
  endtask

  initial begin
    reset = 0; idle(); id_pc = 32'h3000; imm16 = 0; jmp_addr = 0;
    jmp_reg = 0; epc = 0;
    m_pc = 32'h3000; m_pend_pc = 0; m_valid = 0; m_pend = 0;
    m_rcnt = 0; m_scnt = 0;
    repeat (2) @(negedge clk);
    exc_req = 1;
    #1;
    chk("rst_pc", pc0, 32'h3000);
    chk("rst_valid", 32'(vld0), 32'd0);
    chk("rst_flush", 32'(fl0), 32'd0);
    exc_req = 0;
    @(negedge clk);
    reset = 1;

    // Boot then sequential fetch
    repeat (4) cyc();
    chk("seq_pc", pc0, 32'h300C);

    // Taken branch with fire
    id_valid = 1; npc_op = 2'd1; cmp = 1; id_pc = 32'h3000; imm16 = 16'h0003;
    cyc();
    chk("beq_pc", pc0, 32'h3010);

    // Taken branch while imem not ready -> pending, second redirect ignored
    idle(); eret_req = 1; epc = 32'h3004;
    cyc();
    idle(); id_valid = 1; npc_op = 2'd1; cmp = 1; id_pc = 32'h3000; imm16 = 16'h0003;
    imem_ready = 0;
    cyc();
    imm16 = 16'h0040;
    cyc();
    chk("pend_hold", pc0, 32'h3004);
    idle();
    cyc();
    chk("pend_pc", pc0, 32'h3010);
    cyc();

    // JR under stall is ignored, then taken
    id_valid = 1; npc_op = 2'd3; jmp_reg = 32'h0000_3ABC; stall = 1;
    cyc();
    chk("jr_stall", pc0, 32'h3014);
    stall = 0;
    cyc();
    chk("jr_pc", pc0, 32'h3ABC);

    // Exception in PEND beats ERET, stall and imem_ready
    npc_op = 2'd1; cmp = 1; id_pc = 32'h3AB8; imm16 = 16'h0010; imem_ready = 0;
    cyc();
    idle(); exc_req = 1; eret_req = 1; epc = 32'h5000; stall = 1; imem_ready = 0;
    cyc();
    chk("exc_pc", pc0, 32'h4180);
    idle();
    cyc();
    chk("exc_nopend", pc0, 32'h4184);

    // J taking upper bits from the slot
    id_valid = 1; npc_op = 2'd2; id_pc = 32'hBFFF_FFFC; jmp_addr = 26'h0000010;
    cyc();
    chk("j_pc", pc0, 32'hC000_0040);

    // Misaligned register target is loaded as-is
    npc_op = 2'd3; jmp_reg = 32'h0000_3ABE;
    cyc();
    chk("mis_flag", 32'(mis1), 32'd1);

    // Sequential wrap at the top of the address space
    idle(); eret_req = 1; epc = 32'hFFFF_FFFC;
    cyc();
    idle();
    cyc();
    chk("wrap_pc", pc0, 32'h0000_0000);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      id_valid   = $urandom_range(0, 3) != 0;
      npc_op     = 2'($urandom_range(0, 3));
      cmp        = $urandom_range(0, 1) == 1;
      stall      = $urandom_range(0, 3) == 0;
      imem_ready = $urandom_range(0, 2) != 0;
      exc_req    = $urandom_range(0, 31) == 0;
      eret_req   = $urandom_range(0, 31) == 0;
      id_pc      = $urandom & 32'hFFFF_FFFC;
      imm16      = 16'($urandom);
      jmp_addr   = 26'($urandom);
      jmp_reg    = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      epc        = $urandom & 32'hFFFF_FFFC;
      cyc();
    end

    // Asynchronous reset takes effect between clock edges
    idle(); exc_req = 1; reset = 0;
    #1;
    chk("arst_pc", pc1, 32'h3000);
    chk("arst_valid", 32'(vld1), 32'd0);
    chk("arst_flush", 32'(fl1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
